// File: rtl/serial_adder_if.sv
// serial_adder_if
// Groups the start/done handshake, operands and result of the bit-serial adder.
//   master : requester side   - drives start, a, b, cin; observes busy, done, sum, cout
//   slave  : adder side       - observes start, a, b, cin; drives busy, done, sum, cout
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial ripple adder: one full-adder slice reused WIDTH times, LSB first,
// with a registered carry. {cout,sum} = a + b + cin.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | one slice per cycle; busy=1; last slice loads sum/cout
// DONE  | done=1 for one cycle; start ignored; always returns to IDLE
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic             busy_nx, done_nx;
   logic [WIDTH-1:0] a_sr, b_sr, psum;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s, co, last;

   // the full-adder slice
   assign s    = a_sr[0] ^ b_sr[0] ^ carry;
   assign co   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign last = (cnt == LAST);

   always_comb begin
      state_nx = state;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = SHIFT;
               busy_nx  = 1'b1;
            end
         end
         SHIFT: begin
            if (last) begin
               state_nx = DONE;
               done_nx  = 1'b1;
            end else begin
               busy_nx  = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // busy/done are registered copies of the next-state decode so that
   // every output comes straight from a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_nx;
         bus.busy <= busy_nx;
         bus.done <= done_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         psum     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.b;
                  carry <= bus.cin;
                  cnt   <= '0;
                  psum  <= '0;
               end
            end
            SHIFT: begin
               a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               carry <= co;
               psum  <= {s, psum[WIDTH-1:1]};
               cnt   <= cnt + 1'b1;
               if (last) begin
                  bus.sum  <= {s, psum[WIDTH-1:1]};
                  bus.cout <= co;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive an accepted start; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = cv;
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      int n;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         cycle();
         n++;
         if (bus.done) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit seen;
      total++;
      if ({bus.busy, bus.done, bus.sum, bus.cout} !== 11'b0) begin
         $display("FAIL reset_pwr: got busy=%b done=%b sum=%h cout=%b expected all 0",
                  bus.busy, bus.done, bus.sum, bus.cout);
      end else passed++;
      // nonzero result first so the reset has something to clear
      start_op(8'h80, 8'h81, 1'b0);
      wait_done(20, seen);
      total++;
      if (!seen || bus.sum !== 8'h01 || bus.cout !== 1'b1) begin
         $display("FAIL reset_pre: seen=%b got sum=%h cout=%b expected sum=01 cout=1",
                  seen, bus.sum, bus.cout);
      end else passed++;
      cycle();
      start_op(8'h12, 8'h34, 1'b0);
      cycle();
      cycle();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         $display("FAIL reset_async_ctl: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end else passed++;
      total++;
      if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
         $display("FAIL reset_async_res: got sum=%h cout=%b expected 00 0", bus.sum, bus.cout);
      end else passed++;
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_zero_add();
      int edges;
      int busy_cnt;
      int done_cnt;
      bit seen;
      edges    = 0;
      busy_cnt = 0;
      seen     = 1'b0;
      bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0; bus.start = 1'b1;
      while (!seen && edges < 20) begin
         cycle();
         edges++;
         bus.start = 1'b0;
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
      end
      total++;
      if (edges !== WIDTH + 1 || !seen) begin
         $display("FAIL zero_latency: got done after %0d edges (seen=%b) expected %0d",
                  edges, seen, WIDTH + 1);
      end else passed++;
      total++;
      if (busy_cnt !== WIDTH) begin
         $display("FAIL zero_busy_len: got %0d cycles expected %0d", busy_cnt, WIDTH);
      end else passed++;
      total++;
      if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
         $display("FAIL zero_result: got sum=%h cout=%b expected 00 0", bus.sum, bus.cout);
      end else passed++;
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (bus.done) done_cnt++;
      end
      total++;
      if (done_cnt !== 0) begin
         $display("FAIL zero_done_pulse: got %0d extra done cycles expected 0", done_cnt);
      end else passed++;
   endtask

   task automatic test_sequence();
      bit seen;
      int hold_bad;
      int n;
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(20, seen);
      total++;
      if (!seen || bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
         $display("FAIL seq_ff01: seen=%b got sum=%h cout=%b expected 00 1",
                  seen, bus.sum, bus.cout);
      end else passed++;
      cycle();
      start_op(8'h3C, 8'h42, 1'b1);
      hold_bad = 0;
      n        = 0;
      seen     = 1'b0;
      if (bus.sum !== 8'h00 || bus.cout !== 1'b1) hold_bad++;
      while (!seen && n < 20) begin
         cycle();
         n++;
         if (bus.done) seen = 1'b1;
         else if (bus.sum !== 8'h00 || bus.cout !== 1'b1) hold_bad++;
      end
      total++;
      if (hold_bad !== 0) begin
         $display("FAIL seq_hold: got %0d cycles with changed result expected 0", hold_bad);
      end else passed++;
      total++;
      if (!seen || bus.sum !== 8'h7F || bus.cout !== 1'b0) begin
         $display("FAIL seq_3c42: seen=%b got sum=%h cout=%b expected 7f 0",
                  seen, bus.sum, bus.cout);
      end else passed++;
      cycle();
   endtask

   task automatic test_isolation();
      int dones;
      int first;
      start_op(8'hA5, 8'h5A, 1'b1);
      bus.a   = 8'h00;
      bus.b   = 8'h00;
      bus.cin = 1'b0;
      dones = 0;
      first = 0;
      for (int e = 2; e <= 22; e++) begin
         cycle();
         if (e == 4) bus.start = 1'b1;
         if (e == 5) bus.start = 1'b0;
         if (bus.done) begin
            dones++;
            if (first == 0) first = e;
         end
      end
      total++;
      if (dones !== 1 || first !== WIDTH + 1) begin
         $display("FAIL iso_done: got %0d dones first at edge %0d expected 1 at %0d",
                  dones, first, WIDTH + 1);
      end else passed++;
      total++;
      if (bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
         $display("FAIL iso_result: got sum=%h cout=%b expected 00 1", bus.sum, bus.cout);
      end else passed++;
   endtask

   task automatic test_back_to_back();
      int dones;
      int last_e;
      int bad_gap;
      int bad_res;
      dones   = 0;
      last_e  = 0;
      bad_gap = 0;
      bad_res = 0;
      bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
      for (int e = 1; e <= 39; e++) begin
         cycle();
         if (bus.done) begin
            if (dones == 0 && e !== WIDTH + 1) bad_gap++;
            if (dones > 0 && e - last_e !== WIDTH + 2) bad_gap++;
            if (bus.sum !== 8'h30 || bus.cout !== 1'b0) bad_res++;
            dones++;
            last_e = e;
         end
      end
      bus.start = 1'b0;
      total++;
      if (dones !== 4) begin
         $display("FAIL b2b_count: got %0d dones expected 4", dones);
      end else passed++;
      total++;
      if (bad_gap !== 0) begin
         $display("FAIL b2b_spacing: got %0d bad intervals expected 0", bad_gap);
      end else passed++;
      total++;
      if (bad_res !== 0) begin
         $display("FAIL b2b_result: got %0d bad results expected 0 (last sum=%h)",
                  bad_res, bus.sum);
      end else passed++;
      cycle();
      cycle();
   endtask

   task automatic test_reset_abort();
      int dones;
      bit seen;
      start_op(8'h0F, 8'h01, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.sum !== 8'h00 || bus.busy !== 1'b0) begin
         $display("FAIL abort_clear: got sum=%h busy=%b expected 00 0", bus.sum, bus.busy);
      end else passed++;
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         cycle();
         if (bus.done) dones++;
      end
      total++;
      if (dones !== 0 || bus.sum !== 8'h00) begin
         $display("FAIL abort_nodone: got %0d dones sum=%h expected 0 dones sum=00",
                  dones, bus.sum);
      end else passed++;
      start_op(8'h80, 8'h80, 1'b0);
      wait_done(20, seen);
      total++;
      if (!seen || bus.sum !== 8'h00 || bus.cout !== 1'b1) begin
         $display("FAIL abort_after: seen=%b got sum=%h cout=%b expected 00 1",
                  seen, bus.sum, bus.cout);
      end else passed++;
      cycle();
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      #1;
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      cycle();

      test_reset();
      test_zero_add();
      test_sequence();
      test_isolation();
      test_back_to_back();
      test_reset_abort();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
